// File: rtl/sampler_pkg.sv
// Shared types, constants and helpers for the sampler voice mixer.
package sampler_pkg;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned SAT_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SAT   = 2'd2,
      WRITE = 2'd3
   } mixer_state_e;

   // Unity gain in Q1.(gain_w-1): the single integer bit set.
   function automatic logic [31:0] UNITY_GAIN(input int unsigned gain_w);
      return 32'd1 << (gain_w - 1);
   endfunction

   // Clamp a signed value into the range of a signed width-bit number.
   function automatic logic signed [SAT_W-1:0] sat_to_width(
      input logic signed [SAT_W-1:0] value,
      input int unsigned             width
   );
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      if (value > max_v) begin
         return max_v;
      end else if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

endpackage

// File: rtl/sampler_voice_slot.sv
// One voice: one-deep stereo holding register with valid/ready handshake,
// a consume port driven by the mixer, and the voice gain register.
module sampler_voice_slot
   import sampler_pkg::*;
#(
   parameter int unsigned SAMPLE_W = 24,
   parameter int unsigned GAIN_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2*SAMPLE_W-1:0] sample_in,
   input  logic                  valid,
   output logic                  ready,
   input  logic                  consume,
   output logic                  held,
   output logic [2*SAMPLE_W-1:0] sample,
   input  logic                  gain_wr,
   input  logic [GAIN_W-1:0]     gain_in,
   output logic [GAIN_W-1:0]     gain
);

   logic load_c;
   logic held_next_c;

   // Load wins over consume so a same-cycle refill keeps the register full;
   // the mixer reads the old content combinationally in that cycle.
   always_comb begin
      load_c      = valid & ready;
      held_next_c = held;
      if (load_c) begin
         held_next_c = 1'b1;
      end else if (consume) begin
         held_next_c = 1'b0;
      end
   end

   // Holding register and handshake state.
   always_ff @(posedge clk) begin
      if (reset) begin
         held   <= 1'b0;
         ready  <= 1'b1;
         sample <= '0;
      end else begin
         held  <= held_next_c;
         ready <= ~held_next_c;
         if (load_c) begin
            sample <= sample_in;
         end
      end
   end

   // Gain register, unity out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         gain <= GAIN_W'(UNITY_GAIN(GAIN_W));
      end else if (gain_wr) begin
         gain <= gain_in;
      end
   end

endmodule

// File: rtl/sampler_voice_mixer.sv
// N-voice stereo mixer: on each sample tick a time-multiplexed MAC sums the
// gain-scaled voices, saturates, and writes one {left,right} frame.
module sampler_voice_mixer
   import sampler_pkg::*;
#(
   parameter  int unsigned NUM_VOICES = 4,
   parameter  int unsigned SAMPLE_W   = 24,
   parameter  int unsigned GAIN_W     = 8,
   localparam int unsigned IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_VOICES*2*SAMPLE_W-1:0] voice_data,
   input  logic [NUM_VOICES-1:0]            voice_valid,
   output logic [NUM_VOICES-1:0]            voice_ready,
   input  logic                             gain_wr,
   input  logic [IDX_W-1:0]                 gain_addr,
   input  logic [GAIN_W-1:0]                gain_data,
   input  logic                             master_mute,
   input  logic                             sample_tick,
   input  logic                             fifo_full,
   output logic [2*SAMPLE_W-1:0]            data_in,
   output logic                             data_wr,
   output logic                             busy,
   output logic [CNT_W-1:0]                 underrun_cnt,
   output logic [CNT_W-1:0]                 overrun_cnt
);

   localparam int unsigned FRAME_W  = 2 * SAMPLE_W;
   localparam int unsigned PROD_W   = SAMPLE_W + GAIN_W + 1;
   localparam int unsigned ACC_W    = SAMPLE_W + GAIN_W + $clog2(NUM_VOICES) + 1;
   localparam int unsigned LAST_IDX = NUM_VOICES - 1;

   mixer_state_e state;
   mixer_state_e state_next;

   logic [IDX_W-1:0]        idx;
   logic signed [ACC_W-1:0] acc_l;
   logic signed [ACC_W-1:0] acc_r;

   logic [NUM_VOICES-1:0] slot_held;
   logic [NUM_VOICES-1:0] slot_consume;
   logic [NUM_VOICES-1:0] slot_gain_wr;
   logic [FRAME_W-1:0]    slot_sample [NUM_VOICES];
   logic [GAIN_W-1:0]     slot_gain   [NUM_VOICES];

   logic                      cur_held_c;
   logic [FRAME_W-1:0]        cur_sample_c;
   logic [GAIN_W-1:0]         cur_gain_c;
   logic signed [SAMPLE_W-1:0] cur_l_c;
   logic signed [SAMPLE_W-1:0] cur_r_c;
   logic signed [GAIN_W:0]    gain_s_c;
   logic signed [PROD_W-1:0]  prod_l_c;
   logic signed [PROD_W-1:0]  prod_r_c;
   logic signed [ACC_W-1:0]   shift_l_c;
   logic signed [ACC_W-1:0]   shift_r_c;
   logic [SAMPLE_W-1:0]       sat_l_c;
   logic [SAMPLE_W-1:0]       sat_r_c;

   logic acc_clear_c;
   logic acc_en_c;
   logic frame_load_c;
   logic wr_next_c;

   // Voice slots; gain writes to addresses beyond the last voice match nothing.
   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
      assign slot_consume[v] = (state == ACCUM) && (idx == IDX_W'(v));
      assign slot_gain_wr[v] = gain_wr && (gain_addr == IDX_W'(v));

      sampler_voice_slot #(
         .SAMPLE_W (SAMPLE_W),
         .GAIN_W   (GAIN_W)
      ) u_slot (
         .clk       (clk),
         .reset     (reset),
         .sample_in (voice_data[v*FRAME_W +: FRAME_W]),
         .valid     (voice_valid[v]),
         .ready     (voice_ready[v]),
         .consume   (slot_consume[v]),
         .held      (slot_held[v]),
         .sample    (slot_sample[v]),
         .gain_wr   (slot_gain_wr[v]),
         .gain_in   (gain_data),
         .gain      (slot_gain[v])
      );
   end

   // Select the voice addressed by the MAC index.
   always_comb begin
      cur_held_c   = 1'b0;
      cur_sample_c = '0;
      cur_gain_c   = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (idx == IDX_W'(v)) begin
            cur_held_c   = slot_held[v];
            cur_sample_c = slot_sample[v];
            cur_gain_c   = slot_gain[v];
         end
      end
   end

   // Signed sample times unsigned gain, and the saturated frame result.
   always_comb begin
      cur_l_c   = cur_sample_c[FRAME_W-1:SAMPLE_W];
      cur_r_c   = cur_sample_c[SAMPLE_W-1:0];
      gain_s_c  = {1'b0, cur_gain_c};
      prod_l_c  = PROD_W'(cur_l_c) * PROD_W'(gain_s_c);
      prod_r_c  = PROD_W'(cur_r_c) * PROD_W'(gain_s_c);
      shift_l_c = acc_l >>> (GAIN_W - 1);
      shift_r_c = acc_r >>> (GAIN_W - 1);
      sat_l_c   = SAMPLE_W'(sat_to_width(SAT_W'(shift_l_c), SAMPLE_W));
      sat_r_c   = SAMPLE_W'(sat_to_width(SAT_W'(shift_r_c), SAMPLE_W));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_next   = state;
      acc_clear_c  = 1'b0;
      acc_en_c     = 1'b0;
      frame_load_c = 1'b0;
      wr_next_c    = 1'b0;
      case (state)
         IDLE: begin
            if (sample_tick) begin
               state_next  = ACCUM;
               acc_clear_c = 1'b1;
            end
         end
         ACCUM: begin
            acc_en_c = 1'b1;
            if (idx == IDX_W'(LAST_IDX)) begin
               state_next = SAT;
            end
         end
         SAT: begin
            frame_load_c = 1'b1;
            state_next   = WRITE;
         end
         WRITE: begin
            if (!fifo_full) begin
               wr_next_c  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Accumulators, output frame, strobes and saturating event counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx          <= '0;
         acc_l        <= '0;
         acc_r        <= '0;
         data_in      <= '0;
         data_wr      <= 1'b0;
         busy         <= 1'b0;
         underrun_cnt <= '0;
         overrun_cnt  <= '0;
      end else begin
         data_wr <= wr_next_c;
         busy    <= (state_next != IDLE);
         if (acc_clear_c) begin
            idx   <= '0;
            acc_l <= '0;
            acc_r <= '0;
         end else if (acc_en_c) begin
            idx <= idx + IDX_W'(1);
            if (cur_held_c) begin
               acc_l <= acc_l + ACC_W'(prod_l_c);
               acc_r <= acc_r + ACC_W'(prod_r_c);
            end else if (underrun_cnt != '1) begin
               underrun_cnt <= underrun_cnt + CNT_W'(1);
            end
         end
         if (frame_load_c) begin
            data_in <= master_mute ? '0 : {sat_l_c, sat_r_c};
         end
         if (sample_tick && (state != IDLE) && (overrun_cnt != '1)) begin
            overrun_cnt <= overrun_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sampler_voice_mixer.sv
// Directed bench for sampler_voice_mixer (4 voices, 24-bit samples, 8-bit gain).
module tb_sampler_voice_mixer;

   localparam int unsigned NV = 4;
   localparam int unsigned SW = 24;
   localparam int unsigned GW = 8;
   localparam int unsigned FW = 2 * SW;

   logic              clk = 1'b0;
   logic              reset;
   logic [NV*FW-1:0]  voice_data;
   logic [NV-1:0]     voice_valid;
   logic [NV-1:0]     voice_ready;
   logic              gain_wr;
   logic [1:0]        gain_addr;
   logic [GW-1:0]     gain_data;
   logic              master_mute;
   logic              sample_tick;
   logic              fifo_full;
   logic [FW-1:0]     data_in;
   logic              data_wr;
   logic              busy;
   logic [15:0]       underrun_cnt;
   logic [15:0]       overrun_cnt;

   int checks = 0;
   int errors = 0;

   sampler_voice_mixer #(
      .NUM_VOICES (NV),
      .SAMPLE_W   (SW),
      .GAIN_W     (GW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .voice_data   (voice_data),
      .voice_valid  (voice_valid),
      .voice_ready  (voice_ready),
      .gain_wr      (gain_wr),
      .gain_addr    (gain_addr),
      .gain_data    (gain_data),
      .master_mute  (master_mute),
      .sample_tick  (sample_tick),
      .fifo_full    (fifo_full),
      .data_in      (data_in),
      .data_wr      (data_wr),
      .busy         (busy),
      .underrun_cnt (underrun_cnt),
      .overrun_cnt  (overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_gain(input logic [1:0] a, input logic [GW-1:0] g);
      gain_addr = a;
      gain_data = g;
      gain_wr   = 1'b1;
      step();
      gain_wr   = 1'b0;
   endtask

   task automatic load_voices(input logic [SW-1:0] l, input logic [SW-1:0] r,
                              input logic [NV-1:0] mask);
      for (int v = 0; v < NV; v++) begin
         voice_data[v*FW +: FW] = {l, r};
      end
      voice_valid = mask;
      step();
      voice_valid = '0;
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
   endtask

   task automatic wait_wr(input int budget, output int n);
      n = 0;
      while (data_wr !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      if (data_wr !== 1'b1) begin
         check("wr_timeout", 64'(data_wr), 64'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int n;
      int pulses;
      reset       = 1'b1;
      voice_data  = '0;
      voice_valid = '0;
      gain_wr     = 1'b0;
      gain_addr   = '0;
      gain_data   = '0;
      master_mute = 1'b0;
      sample_tick = 1'b0;
      fifo_full   = 1'b0;
      step();
      step();
      check("rst_ready",    64'(voice_ready),  64'hF);
      check("rst_data_in",  64'(data_in),      64'h0);
      check("rst_data_wr",  64'(data_wr),      64'h0);
      check("rst_busy",     64'(busy),         64'h0);
      check("rst_underrun", 64'(underrun_cnt), 64'h0);
      check("rst_overrun",  64'(overrun_cnt),  64'h0);
      reset = 1'b0;
      step();

      // Basic unity-gain frame and latency.
      load_voices(24'h000100, 24'hFFFF00, 4'hF);
      check("t1_ready_low", 64'(voice_ready), 64'h0);
      tick();
      check("t1_busy", 64'(busy), 64'h1);
      step();
      check("t1_ready_v0", 64'(voice_ready), 64'h1);
      wait_wr(20, n);
      check("t1_latency", 64'(n), 64'd5);
      check("t1_data", 64'(data_in), 64'h000400FFFC00);
      check("t1_ready_all", 64'(voice_ready), 64'hF);
      check("t1_busy_done", 64'(busy), 64'h0);
      step();
      check("t1_wr_pulse", 64'(data_wr), 64'h0);

      // Mixed gains, unsaturated.
      write_gain(2'd0, 8'h40);
      write_gain(2'd1, 8'h80);
      write_gain(2'd2, 8'h00);
      write_gain(2'd3, 8'hFF);
      load_voices(24'h100000, 24'h000000, 4'hF);
      tick();
      wait_wr(20, n);
      check("t2_gain_mix", 64'(data_in), 64'h37E000000000);
      step();
      for (int v = 0; v < NV; v++) begin
         write_gain(2'(v), 8'h80);
      end

      // Positive and negative saturation.
      load_voices(24'h7FFFFF, 24'h800000, 4'hF);
      tick();
      wait_wr(20, n);
      check("t3_sat", 64'(data_in), 64'h7FFFFF800000);
      step();

      // Underruns.
      load_voices(24'h000010, 24'h000000, 4'b0101);
      tick();
      wait_wr(20, n);
      check("t4_data", 64'(data_in), 64'h000020000000);
      check("t4_underrun", 64'(underrun_cnt), 64'd2);
      step();
      tick();
      wait_wr(20, n);
      check("t4_empty_data", 64'(data_in), 64'h0);
      check("t4_underrun2", 64'(underrun_cnt), 64'd6);
      step();

      // FIFO full stall with a dropped tick.
      load_voices(24'h000001, 24'h000002, 4'hF);
      fifo_full = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         step();
      end
      check("t5_busy_write", 64'(busy), 64'h1);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) sample_tick = 1'b1;
         step();
         sample_tick = 1'b0;
         check("t5_stall_wr", 64'(data_wr), 64'h0);
         check("t5_stall_data", 64'(data_in), 64'h000004000008);
      end
      fifo_full = 1'b0;
      step();
      check("t5_wr", 64'(data_wr), 64'h1);
      check("t5_overrun", 64'(overrun_cnt), 64'd1);
      step();
      check("t5_wr_once", 64'(data_wr), 64'h0);
      check("t5_no_new_frame", 64'(busy), 64'h0);

      // Master mute still consumes voices.
      master_mute = 1'b1;
      load_voices(24'h123456, 24'h654321, 4'hF);
      tick();
      wait_wr(20, n);
      check("t6_mute_data", 64'(data_in), 64'h0);
      check("t6_mute_ready", 64'(voice_ready), 64'hF);
      master_mute = 1'b0;
      step();

      // Reset mid-frame restores gains and aborts the write.
      write_gain(2'd1, 8'h10);
      load_voices(24'h000100, 24'h000100, 4'hF);
      tick();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t7_busy", 64'(busy), 64'h0);
      check("t7_underrun", 64'(underrun_cnt), 64'h0);
      check("t7_overrun", 64'(overrun_cnt), 64'h0);
      check("t7_ready", 64'(voice_ready), 64'hF);
      check("t7_data", 64'(data_in), 64'h0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (data_wr === 1'b1) pulses++;
      end
      check("t7_no_wr", 64'(pulses), 64'd0);
      load_voices(24'h000100, 24'h000000, 4'b0010);
      tick();
      wait_wr(20, n);
      check("t7_gain_unity", 64'(data_in), 64'h000100000000);
      check("t7_underrun3", 64'(underrun_cnt), 64'd3);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sampler_voice_mixer.md
Name: sampler_voice_mixer

Overview:
- Parametrised N-voice stereo mixer feeding the codec data FIFO.
- Each voice streams stereo samples through a one-deep holding register.
- On every sample tick from the codec unit, a time-multiplexed MAC sums gain-scaled voices, saturates the result, and writes one {left,right} frame to the FIFO.
- Replaces the direct single-stream data_in/data_wr path in the sampler top.

Parameters:
- NUM_VOICES, 4, number of voice inputs (1..16).
- SAMPLE_W, 24, signed sample width per channel.
- GAIN_W, 8, unsigned gain width, Q1.(GAIN_W-1); 2^(GAIN_W-1) is unity.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- voice_data  in  NUM_VOICES*2*SAMPLE_W  per voice v, {left,right} at slice [v*2*SAMPLE_W +: 2*SAMPLE_W]; left is the upper half.
- voice_valid  in  NUM_VOICES  per-voice sample valid.
- voice_ready  out  NUM_VOICES  per-voice holding register empty.
- gain_wr  in  1  gain write strobe.
- gain_addr  in  clog2(NUM_VOICES) (min 1)  voice index.
- gain_data  in  GAIN_W  gain value.
- master_mute  in  1  force output frames to zero.
- sample_tick  in  1  one-cycle pulse per audio frame.
- fifo_full  in  1  codec data FIFO full.
- data_in  out  2*SAMPLE_W  mixed frame {left,right}.
- data_wr  out  1  one-cycle FIFO write strobe.
- busy  out  1  FSM not in IDLE.
- underrun_cnt  out  16  voice-slots mixed with no sample held.
- overrun_cnt  out  16  sample_ticks dropped while busy.

Behaviour:
- Reset values:
  - voice_ready all 1; data_in 0; data_wr 0; busy 0; both counters 0.
  - All holding registers empty.
  - All gains set to unity (2^(GAIN_W-1)).
- Holding register per voice:
  - Loads on voice_valid[v] & voice_ready[v]; voice_ready[v] falls the next cycle.
  - Emptied when the MAC consumes that voice.
  - Load and consume of the same voice in the same cycle: the consume applies to the old content, and the new sample loads (register stays full).
- Gain write: gain_wr takes effect the next cycle. Writes with gain_addr >= NUM_VOICES are ignored. A write during a frame affects only voices not yet consumed.
- FSM states and transitions:
  - IDLE: sample_tick -> ACCUM; clear left/right accumulators and the voice index.
  - ACCUM: one voice per cycle, index 0..NUM_VOICES-1.
    - If the voice is held: acc += sample * gain (signed x unsigned).
    - If not held: add nothing and increment underrun_cnt (saturating at 0xFFFF).
    - After the last voice -> SAT.
  - SAT: result = acc >>> (GAIN_W-1), clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] per channel. master_mute forces 0. Registers the result into data_in, then -> WRITE.
  - WRITE: if !fifo_full, pulse data_wr for one cycle and -> IDLE. If fifo_full, hold in WRITE with data_in stable and data_wr low.
- Widths: accumulator width is SAMPLE_W + GAIN_W + clog2(NUM_VOICES) + 1. No intermediate overflow is possible.
- Latency: sample_tick at cycle T gives the earliest data_wr at T+NUM_VOICES+3 (IDLE->ACCUM at T+1; SAT at T+NUM_VOICES+1; WRITE at T+NUM_VOICES+2; strobe visible T+NUM_VOICES+3).
- sample_tick while busy: dropped, overrun_cnt increments (saturating), the current frame is unaffected.
- sample_tick in the cycle WRITE completes: that cycle is still busy, so the tick is dropped.
- busy equals (state != IDLE).
- Reset mid-frame: abort, no data_wr, all state returns to reset values including gains.

Decomposition:
- Package sampler_pkg:
  - mixer_state_e enum {IDLE, ACCUM, SAT, WRITE}.
  - UNITY_GAIN function of GAIN_W.
  - sat_to_width function (signed clamp).
  - CNT_W=16 constant.
- Sub-module sampler_voice_slot: one per voice, instantiated in a generate loop. Contains the holding register, ready/valid handshake, consume port and gain register.

Test Plan:
- Reset, all voices valid with left=0x000100, right=0xFFFF00, unity gains; tick -> data_wr at T+7 with data_in={0x000400, 0xFFFC00}; all voice_ready fall after load and rise after consume.
- Gains {0x40, 0x80, 0, 0xFF}, each voice left=0x100000 -> left=0x100000*(0.5+1+0+1.9921875)=0x37E000, unsaturated.
- Four voices at 0x7FFFFF with unity gain -> left=0x7FFFFF clamped; four at 0x800000 -> 0x800000.
- Voices 1 and 3 never valid, voices 0 and 2 at 0x000010 -> data_in left=0x000020 and underrun_cnt=2 after one frame; second tick with no new data -> frame of 0, underrun_cnt=6.
- fifo_full high for 10 cycles at WRITE -> data_in stable, no data_wr until fifo_full falls, then exactly one pulse; a tick during the stall gives overrun_cnt=1.
- master_mute=1 with nonzero voices -> data_in=0, data_wr pulses, holding registers consumed. Reset asserted at cycle T+3 of a frame -> no data_wr, gains back to 0x80.
